cpu_gen2: RTL

CPU_GEN2 -- requirements
Module: cpu_gen2

---
 rtl/cpu_gen2.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cpu_gen2.sv
// rtl/cpu_gen2.sv - 8-bit multi-cycle CPU on a byte-wide req/ready memory port; BZ/BC enabled by CPU_GEN2_BRANCH_EN
module cpu_gen2 #(
   parameter int REG_CNT      = 16,
   parameter int ADDR_W       = 16,
   parameter int RESET_VECTOR = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] addr,
   input  logic [7:0]        di,
   output logic [7:0]        dout,
   output logic              we,
   output logic              req,
   input  logic              ready,
   output logic              halted
);

   localparam int                RI_W = $clog2(REG_CNT);
   localparam logic [ADDR_W-1:0] RV   = ADDR_W'(RESET_VECTOR);

   localparam logic [7:0] OP_HALT = 8'h00, OP_LD  = 8'h01, OP_ST  = 8'h02, OP_LDI = 8'h03;
   localparam logic [7:0] OP_MOV  = 8'h04, OP_ADD = 8'h05, OP_SUB = 8'h06, OP_AND = 8'h07;
   localparam logic [7:0] OP_OR   = 8'h08, OP_XOR = 8'h09, OP_ROTL = 8'h0A, OP_ROTR = 8'h0B;
   localparam logic [7:0] OP_JMP  = 8'h0C;
`ifdef CPU_GEN2_BRANCH_EN
   localparam logic [7:0] OP_BZ   = 8'h0D, OP_BC  = 8'h0E;
`endif

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED} state_t;

   state_t            state_q, state_d;
   logic [1:0]        beat_q, beat_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic              z_q, z_d, c_q, c_d;
   logic [7:0]        regs_q [REG_CNT];
   logic [7:0]        regs_d [REG_CNT];

   logic [7:0]        op;
   logic [RI_W-1:0]   rd, ra, rb;
   logic [ADDR_W-1:0] data_addr, target;
   logic [7:0]        a_v, b_v, rot_l, rot_r;
   logic [8:0]        sum, diff;
   logic [2:0]        sh;

   assign op        = ir_q[31:24];
   assign rd        = ir_q[16 +: RI_W];
   assign ra        = ir_q[8 +: RI_W];
   assign rb        = ir_q[0 +: RI_W];
   assign data_addr = ir_q[ADDR_W-1:0];
   assign target    = ir_q[8 +: ADDR_W];

   // Operands come from the pre-write register state, so d==a/d==b sees old values
   assign a_v   = regs_q[ra];
   assign b_v   = regs_q[rb];
   assign sum   = {1'b0, a_v} + {1'b0, b_v};
   assign diff  = {1'b0, a_v} - {1'b0, b_v};
   assign sh    = b_v[2:0];
   assign rot_l = (a_v << sh) | (a_v >> (4'd8 - {1'b0, sh}));
   assign rot_r = (a_v >> sh) | (a_v << (4'd8 - {1'b0, sh}));

   assign halted = (state_q == S_HALTED);

   // Memory port: request only in FETCH/MEM, suppressed while reset is asserted
   always_comb begin
      addr = pc_q;
      req  = 1'b0;
      we   = 1'b0;
      dout = 8'h00;
      case (state_q)
         S_FETCH: begin
            addr = pc_q + ADDR_W'(beat_q);
            req  = !rst;
         end
         S_MEM: begin
            addr = data_addr;
            req  = !rst;
            if (op == OP_ST) begin
               we   = !rst;
               dout = regs_q[rd];
            end
         end
         default: ;
      endcase
   end

   // Sequencer, ALU writeback, flags and PC update
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      z_d     = z_q;
      c_d     = c_q;
      regs_d  = regs_q;
      case (state_q)
         S_FETCH: begin
            if (req && ready) begin
               ir_d   = {ir_q[23:0], di};
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op == OP_HALT) begin
               state_d = S_HALTED;
            end else begin
               pc_d    = pc_q + ADDR_W'(4);
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (op)
               OP_LD, OP_ST: state_d = S_MEM;
               OP_LDI: regs_d[rd] = ir_q[15:8];
               OP_MOV: regs_d[rd] = a_v;
               OP_ADD: begin regs_d[rd] = sum[7:0];  z_d = (sum[7:0] == 8'h00);  c_d = sum[8];  end
               OP_SUB: begin regs_d[rd] = diff[7:0]; z_d = (diff[7:0] == 8'h00); c_d = diff[8]; end
               OP_AND: begin regs_d[rd] = a_v & b_v; z_d = ((a_v & b_v) == 8'h00); c_d = 1'b0; end
               OP_OR:  begin regs_d[rd] = a_v | b_v; z_d = ((a_v | b_v) == 8'h00); c_d = 1'b0; end
               OP_XOR: begin regs_d[rd] = a_v ^ b_v; z_d = ((a_v ^ b_v) == 8'h00); c_d = 1'b0; end
               OP_ROTL: begin regs_d[rd] = rot_l; z_d = (rot_l == 8'h00); end
               OP_ROTR: begin regs_d[rd] = rot_r; z_d = (rot_r == 8'h00); end
               OP_JMP: pc_d = target;
`ifdef CPU_GEN2_BRANCH_EN
               OP_BZ: if (z_q) pc_d = target;
               OP_BC: if (c_q) pc_d = target;
`endif
               default: ;
            endcase
         end
         S_MEM: begin
            if (req && ready) begin
               if (op == OP_LD) regs_d[rd] = di;
               state_d = S_FETCH;
            end
         end
         S_HALTED: ;
         default: state_d = S_FETCH;
      endcase
   end

   // State register with synchronous reset that abandons any in-flight access
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         beat_q  <= 2'd0;
         pc_q    <= RV;
         ir_q    <= 32'h0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         for (int i = 0; i < REG_CNT; i++) regs_q[i] <= 8'h00;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         z_q     <= z_d;
         c_q     <= c_d;
         regs_q  <= regs_d;
      end
   end

endmodule
